// File: rtl/note_sequencer.sv
// Note-memory sequencer: plays a preloaded list of 4-bit note codes, each held for tempo+1 clocks,
// with pause, stop and loop control.
module note_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TEMPO_W = 8,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               loop_en,
  input  logic [AW:0]        len,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic               load_we,
  input  logic [AW-1:0]      load_addr,
  input  logic [3:0]         load_data,
  output logic               Tom,
  output logic               notas3,
  output logic               notas2,
  output logic               notas1,
  output logic               playing,
  output logic [AW-1:0]      step,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StPlay, StPause} state_e;

  state_e             state_q, state_d;
  logic [TEMPO_W-1:0] cnt_q, cnt_d;
  logic [TEMPO_W-1:0] tempo_q, tempo_d;
  logic [AW:0]        len_q, len_d;
  logic [AW-1:0]      step_q, step_d;
  logic [3:0]         note_q, note_d;
  logic               done_q, done_d;
  logic [3:0]         mem_q [DEPTH];
  logic               mem_we;

  logic               start_ok;
  logic               last_step;
  logic               cnt_zero;
  logic [AW-1:0]      step_nxt;

  assign start_ok  = start && (len != '0) && (len <= (AW+1)'(DEPTH));
  assign last_step = ({1'b0, step_q} == (len_q - (AW+1)'(1)));
  assign cnt_zero  = (cnt_q == '0);
  assign step_nxt  = step_q + AW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tempo_q <= '0;
      len_q   <= '0;
      step_q  <= '0;
      note_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tempo_q <= tempo_d;
      len_q   <= len_d;
      step_q  <= step_d;
      note_q  <= note_d;
      done_q  <= done_d;
    end
  end

  // Note memory is deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StPlay;
      end
      StPlay: begin
        if (stop) begin
          state_d = StIdle;
        end else if (pause) begin
          state_d = StPause;
        end else if (cnt_zero && last_step && !loop_en) begin
          state_d = StIdle;
        end
      end
      StPause: begin
        if (stop) begin
          state_d = StIdle;
        end else if (!pause) begin
          state_d = StPlay;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: counter, step, latched settings, note output, done pulse
  always_comb begin
    cnt_d   = cnt_q;
    tempo_d = tempo_q;
    len_d   = len_q;
    step_d  = step_q;
    note_d  = note_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_we = load_we;
        if (start_ok) begin
          len_d   = len;
          tempo_d = tempo;
          step_d  = '0;
          cnt_d   = tempo;
          note_d  = mem_q[0];
        end
      end
      StPlay: begin
        if (stop) begin
          cnt_d  = '0;
          step_d = '0;
          note_d = '0;
        end else if (pause) begin
          // Entering pause freezes everything, including this edge's count.
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - TEMPO_W'(1);
        end else if (!last_step) begin
          step_d = step_nxt;
          note_d = mem_q[step_nxt];
          cnt_d  = tempo_q;
        end else if (loop_en) begin
          step_d = '0;
          note_d = mem_q[0];
          cnt_d  = tempo_q;
        end else begin
          step_d = '0;
          note_d = '0;
          done_d = 1'b1;
        end
      end
      StPause: begin
        if (stop) begin
          cnt_d  = '0;
          step_d = '0;
          note_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    playing = (state_q != StIdle);
    step    = step_q;
    done    = done_q;
    {Tom, notas3, notas2, notas1} = note_q;
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed-vector bench for note_sequencer: playback, looping, pause, stop, load lockout, reset.
module tb_note_sequencer;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TEMPO_W = 8;
  localparam int unsigned AW      = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop, pause, loop_en;
  logic [AW:0]        len;
  logic [TEMPO_W-1:0] tempo;
  logic               load_we;
  logic [AW-1:0]      load_addr;
  logic [3:0]         load_data;
  logic               Tom, notas3, notas2, notas1;
  logic               playing;
  logic [AW-1:0]      step;
  logic               done;
  logic [3:0]         note;

  int n_pass   = 0;
  int n_checks = 0;

  assign note = {Tom, notas3, notas2, notas1};

  always #5 clk = ~clk;

  note_sequencer #(.DEPTH(DEPTH), .TEMPO_W(TEMPO_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .loop_en  (loop_en),
    .len      (len),
    .tempo    (tempo),
    .load_we  (load_we),
    .load_addr(load_addr),
    .load_data(load_data),
    .Tom      (Tom),
    .notas3   (notas3),
    .notas2   (notas2),
    .notas1   (notas1),
    .playing  (playing),
    .step     (step),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [3:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  function automatic logic [3:0] seq_note(input int idx);
    case (idx % 3)
      0:       return 4'b1000;
      1:       return 4'b0011;
      default: return 4'b0101;
    endcase
  endfunction

  task automatic test_reset();
    tick();
    n_checks++; if (note !== 4'b0000) $display("FAIL reset_note got=%b exp=0000", note); else n_pass++;
    n_checks++; if (playing !== 1'b0) $display("FAIL reset_playing got=%b exp=0", playing); else n_pass++;
    n_checks++; if (step !== 4'd0) $display("FAIL reset_step got=%0d exp=0", step); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  // len=3, tempo=2: three cycles per note, then 0000 with a one-cycle done
  task automatic test_play_once();
    load(4'd0, 4'b1000);
    load(4'd1, 4'b0011);
    load(4'd2, 4'b0101);
    len = 5'd3; tempo = 8'd2; loop_en = 1'b0;
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (note !== seq_note(k / 3)) $display("FAIL play_note k=%0d got=%b exp=%b", k, note, seq_note(k / 3));
      else n_pass++;
      n_checks++;
      if (step !== 4'(k / 3)) $display("FAIL play_step k=%0d got=%0d exp=%0d", k, step, k / 3);
      else n_pass++;
      n_checks++;
      if (playing !== 1'b1 || done !== 1'b0)
        $display("FAIL play_flags k=%0d got playing=%b done=%b exp 1/0", k, playing, done);
      else n_pass++;
    end
    tick();
    n_checks++; if (note !== 4'b0000) $display("FAIL end_note got=%b exp=0000", note); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL end_done got=%b exp=1", done); else n_pass++;
    n_checks++; if (playing !== 1'b0) $display("FAIL end_playing got=%b exp=0", playing); else n_pass++;
    n_checks++; if (step !== 4'd0) $display("FAIL end_step got=%0d exp=0", step); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL done_width got=%b exp=0", done); else n_pass++;
  endtask

  task automatic test_loop();
    loop_en = 1'b1;
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (note !== seq_note(k / 3) || done !== 1'b0)
        $display("FAIL loop k=%0d got note=%b done=%b exp note=%b done=0", k, note, done,
                 seq_note(k / 3));
      else n_pass++;
    end
    pulse_stop();
    n_checks++;
    if (note !== 4'b0000 || playing !== 1'b0 || done !== 1'b0)
      $display("FAIL loop_stop got note=%b playing=%b done=%b exp 0000/0/0", note, playing, done);
    else n_pass++;
    loop_en = 1'b0;
  endtask

  // tempo=4; pause high on 5 edges while note 1 plays, plus one exit edge where the count holds
  task automatic test_pause();
    tempo = 8'd4;
    pulse_start();
    for (int k = 1; k <= 16; k++) begin
      pause = (k >= 6 && k <= 10);
      tick();
      if (k >= 5 && k <= 15) begin
        n_checks++;
        if (note !== 4'b0011 || step !== 4'd1 || playing !== 1'b1)
          $display("FAIL pause_hold k=%0d got note=%b step=%0d playing=%b exp 0011/1/1", k, note,
                   step, playing);
        else n_pass++;
      end
    end
    pause = 1'b0;
    n_checks++;
    if (note !== 4'b0101 || step !== 4'd2)
      $display("FAIL pause_resume got note=%b step=%0d exp 0101/2", note, step);
    else n_pass++;
    pulse_stop();
  endtask

  task automatic test_stop_pause();
    tempo = 8'd2;
    pulse_start();
    tick();
    tick();
    tick();
    stop = 1'b1; pause = 1'b1;
    tick();
    stop = 1'b0; pause = 1'b0;
    n_checks++;
    if (note !== 4'b0000 || playing !== 1'b0 || step !== 4'd0 || done !== 1'b0)
      $display("FAIL stop_pause got note=%b playing=%b step=%0d done=%b exp 0000/0/0/0", note,
               playing, step, done);
    else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL stop_no_done got=%b exp=0", done); else n_pass++;
  endtask

  task automatic test_load_lockout();
    pulse_start();
    load(4'd1, 4'b1111);
    pulse_stop();
    pulse_start();
    tick(); tick(); tick();
    n_checks++;
    if (note !== 4'b0011) $display("FAIL load_lockout got=%b exp=0011", note); else n_pass++;
    pulse_stop();
    len = 5'd0;
    pulse_start();
    n_checks++;
    if (playing !== 1'b0 || note !== 4'b0000)
      $display("FAIL len_zero got playing=%b note=%b exp 0/0000", playing, note);
    else n_pass++;
    len = 5'd17;
    pulse_start();
    n_checks++;
    if (playing !== 1'b0) $display("FAIL len_over got playing=%b exp=0", playing); else n_pass++;
    len = 5'd3;
  endtask

  task automatic test_len_one();
    len = 5'd1; tempo = 8'd0;
    pulse_start();
    n_checks++;
    if (note !== 4'b1000 || playing !== 1'b1 || done !== 1'b0)
      $display("FAIL len1_play got note=%b playing=%b done=%b exp 1000/1/0", note, playing, done);
    else n_pass++;
    tick();
    n_checks++;
    if (note !== 4'b0000 || playing !== 1'b0 || done !== 1'b1)
      $display("FAIL len1_end got note=%b playing=%b done=%b exp 0000/0/1", note, playing, done);
    else n_pass++;
    tick();
    len = 5'd3; tempo = 8'd2;
  endtask

  task automatic test_reset_mid();
    pulse_start();
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (note !== 4'b0000 || playing !== 1'b0 || step !== 4'd0 || done !== 1'b0)
      $display("FAIL async_reset got note=%b playing=%b step=%0d done=%b exp 0000/0/0/0", note,
               playing, step, done);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (playing !== 1'b0 || done !== 1'b0)
      $display("FAIL post_reset_idle got playing=%b done=%b exp 0/0", playing, done);
    else n_pass++;
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      if (k % 3 == 0) begin
        n_checks++;
        if (note !== seq_note(k / 3))
          $display("FAIL replay k=%0d got=%b exp=%b", k, note, seq_note(k / 3));
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    len = '0; tempo = '0; load_we = 1'b0; load_addr = '0; load_data = '0;
    test_reset();
    test_play_once();
    test_loop();
    test_pause();
    test_stop_pause();
    test_load_lockout();
    test_len_one();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
